sisc_dmem: RTL and testbench
============================

# sisc_dmem

Multi-cycle data memory responder for the SISC computer. Serves the load/store requests that the control FSM and datapath issue during the execute/mem states (LDA/LDX/STA/STX/LDR/STR/LDP/STP) through a request/ready handshake with a programmable number of wait-states. It is the memory-side end of the `dm_we`/address/data interface. The controller must hold in `mem` until `ready`.

## Interface
Parameters:
- `DATA_W`, 32, data word width
- `ADDR_W`, 16, request address width
- `DEPTH`, 256, number of words implemented (power of two, ≤ 2^ADDR_W)
- `WAIT`, 2, wait-state cycles between accept and response (0..7)

Ports:
- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `req`  in  1  request valid; sampled only in IDLE
- `we`  in  1  1 = write (store), 0 = read (load); sampled with `req`
- `addr`  in  ADDR_W  word address; sampled with `req`
- `wdata`  in  DATA_W  store data; sampled with `req`
- `rdata`  out  DATA_W  load data; valid while `ready`=1, held until next response
- `ready`  out  1  one-cycle response strobe
- `busy`  out  1  high whenever state ≠ IDLE
- `err`  out  1  asserted with `ready` when sampled `addr` ≥ DEPTH

## Operation
- States: IDLE, WAIT, RESP. All outputs registered. Internal registers: `a_q`, `we_q`, `wd_q`, 3-bit counter `cnt`.
- IDLE: if `req`=1, latch `addr`/`we`/`wdata`. If WAIT>0, go to WAIT with `cnt`=WAIT. If WAIT=0, go directly to RESP. If `req`=0, stay.
- WAIT: decrement `cnt` each cycle. Go to RESP on the edge where `cnt`=1.
- Edge entering RESP, in range (`a_q` < DEPTH):
  - Write: `mem[a_q]` ← `wd_q`. `rdata` unchanged.
  - Read: `rdata` ← `mem[a_q]`.
- Edge entering RESP, out of range: no array write; `rdata` ← 0; `err` ← 1.
- RESP: `ready`=1 (and `err` if set) for exactly one cycle, then unconditional return to IDLE. `ready`/`err` cleared on exit.
- `req` while busy (WAIT or RESP) is ignored, not queued. The requester keeps `req` high, or reissues it, after seeing `ready`.
- `req` held high continuously yields back-to-back transactions, each with a one-cycle IDLE gap.
- Array indexed by `a_q[log2(DEPTH)-1:0]`. Contents are zero at time 0 and are not cleared by `rst`.

## Timing
- Reset values: state IDLE, `ready`=0, `busy`=0, `err`=0, `rdata`=0, `cnt`=0.
- Request sampled at the end of cycle 0 (IDLE, `req`=1). `busy`=1 in cycles 1..WAIT+1. `ready`=1 in cycle WAIT+1.
- Latency from request to `ready` is WAIT+1 cycles. Minimum issue interval is WAIT+2 cycles.
- Store data is committed at the edge entering RESP, so a load accepted in the following IDLE returns the new value.
- `rst`=1 in any cycle overrides everything: next state IDLE, all outputs to reset values.
  - If reset precedes the RESP-entry edge, the in-flight store is dropped.
  - A store already committed stays in the array.
- Reset and `req` in the same cycle: reset wins, request is not accepted.

## Test plan
- WAIT=2: store `addr`=0x0010, `wdata`=0xDEADBEEF in cycle 0 -> `busy`=1 in cycles 1–3, `ready`=1 only in cycle 3, `err`=0. Then load 0x0010 -> `ready` 3 cycles after accept with `rdata`=0xDEADBEEF.
- `req` held high for three alternating store/load pairs to addresses 0x00, 0x01, 0xFF -> accepts every 4 cycles, each load returns the matching stored value, no lost or duplicated `ready`.
- Pulse `req` (load 0x0020) in cycle 1 during a busy store to 0x0005 -> second request ignored: exactly one `ready`, and `mem[0x20]` and `rdata` are unchanged by it.
- Store to `addr`=0x0100 with DEPTH=256 -> `ready`=1 and `err`=1 together, `rdata`=0, `mem[0x00]` unchanged. A subsequent in-range load -> `err`=0.
- Store 0x12345678 to 0x0033, assert `rst` in cycle 2 (WAIT=2) -> `busy`/`ready`=0 next cycle, and a later load of 0x0033 returns the prior value 0x00000000.
- WAIT=0: load accepted in cycle 0 -> `ready` in cycle 1. Back-to-back `req` -> one response every 2 cycles.

Source files
------------

// File: rtl/sisc_dmem_if.sv
// Request/response bus between the SISC controller and its data memory.
// The master holds req with we/addr/wdata; the slave answers with a ready pulse.
interface sisc_dmem_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ready;
    logic              busy;
    logic              err;

    modport master (
        output req, we, addr, wdata,
        input  rdata, ready, busy, err
    );

    modport slave (
        input  req, we, addr, wdata,
        output rdata, ready, busy, err
    );
endinterface

// File: rtl/sisc_dmem.sv
// SISC data memory responder: one request at a time, WAIT wait-states,
// then a single-cycle ready (with err for out-of-range addresses).
module sisc_dmem #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 256,
    parameter int WAIT   = 2
) (
    input  logic        clk,
    input  logic        rst,
    sisc_dmem_if.slave  dm
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

    state_e            state_q;
    logic [2:0]        cnt_q;
    logic [ADDR_W-1:0] a_q;
    logic              we_q;
    logic [DATA_W-1:0] wd_q;
    logic [DATA_W-1:0] rdata_q;
    logic              ready_q;
    logic              busy_q;
    logic              err_q;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [ADDR_W-1:0] a_d;
    logic              we_d;
    logic [DATA_W-1:0] wd_d;
    logic              enter_d;
    logic              in_rng_d;
    logic [IW-1:0]     idx_d;

    // With WAIT=0 the RESP-entry edge is the accept edge, so use the live bus.
    always_comb begin
        a_d     = a_q;
        we_d    = we_q;
        wd_d    = wd_q;
        enter_d = 1'b0;
        if (state_q == S_IDLE) begin
            a_d     = dm.addr;
            we_d    = dm.we;
            wd_d    = dm.wdata;
            enter_d = dm.req && (WAIT == 0);
        end else if (state_q == S_WAIT) begin
            enter_d = (cnt_q == 3'd1);
        end
        in_rng_d = {1'b0, a_d} < DEPTH_L;
        idx_d    = a_d[IW-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst && enter_d && in_rng_d && we_d) begin
            mem_q[idx_d] <= wd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            a_q     <= '0;
            we_q    <= 1'b0;
            wd_q    <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (dm.req) begin
                        a_q    <= dm.addr;
                        we_q   <= dm.we;
                        wd_q   <= dm.wdata;
                        busy_q <= 1'b1;
                        cnt_q  <= 3'(WAIT);
                        state_q <= (WAIT == 0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        state_q <= S_RESP;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
            ready_q <= enter_d;
            err_q   <= enter_d && !in_rng_d;
            if (enter_d) begin
                if (!in_rng_d) begin
                    rdata_q <= '0;
                end else if (!we_d) begin
                    rdata_q <= mem_q[idx_d];
                end
            end
        end
    end

    assign dm.rdata = rdata_q;
    assign dm.ready = ready_q;
    assign dm.busy  = busy_q;
    assign dm.err   = err_q;
endmodule

// File: tb/tb_sisc_dmem.sv
// Directed bench for sisc_dmem: a WAIT=2 instance and a WAIT=0 instance
// sharing clock and reset.
module tb_sisc_dmem;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sisc_dmem_if #(.DATA_W(32), .ADDR_W(16)) d2 ();
    sisc_dmem_if #(.DATA_W(32), .ADDR_W(16)) d0 ();

    sisc_dmem #(.DATA_W(32), .ADDR_W(16), .DEPTH(256), .WAIT(2)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .dm  (d2)
    );

    sisc_dmem #(.DATA_W(32), .ADDR_W(16), .DEPTH(256), .WAIT(0)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .dm  (d0)
    );

    int n_chk = 0;
    int n_err = 0;

    logic [15:0] addrs [3] = '{16'h0000, 16'h0001, 16'h00FF};
    logic [31:0] vals  [3] = '{32'h0BAD0001, 32'h0BAD0002, 32'h0BAD00FF};

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic txn(input bit sel, input logic w, input logic [15:0] a,
                       input logic [31:0] d, output logic [31:0] rd,
                       output logic e, output int lat);
        if (sel) begin
            d0.req = 1'b1; d0.we = w; d0.addr = a; d0.wdata = d;
        end else begin
            d2.req = 1'b1; d2.we = w; d2.addr = a; d2.wdata = d;
        end
        tick;
        d0.req = 1'b0;
        d2.req = 1'b0;
        lat = 1;
        while (((sel ? d0.ready : d2.ready) !== 1'b1) && lat < 20) begin
            tick;
            lat++;
        end
        rd = sel ? d0.rdata : d2.rdata;
        e  = sel ? d0.err : d2.err;
        tick;
    endtask

    task automatic st(input bit sel, input logic [15:0] a,
                      input logic [31:0] d, input string tag);
        logic [31:0] rd;
        logic e;
        int lat;
        txn(sel, 1'b1, a, d, rd, e, lat);
        check({tag, "_lat"}, 32'(lat), sel ? 32'd1 : 32'd3);
    endtask

    task automatic ld(input bit sel, input logic [15:0] a,
                      input logic [31:0] exp, input string tag);
        logic [31:0] rd;
        logic e;
        int lat;
        txn(sel, 1'b0, a, 32'h0, rd, e, lat);
        check({tag, "_lat"}, 32'(lat), sel ? 32'd1 : 32'd3);
        check({tag, "_err"}, {31'd0, e}, 32'd0);
        check(tag, rd, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rc;
        bit w;
        logic [31:0] rd;
        logic e;
        int lat;

        rst = 1'b1;
        d2.req = 1'b0; d2.we = 1'b0; d2.addr = '0; d2.wdata = '0;
        d0.req = 1'b0; d0.we = 1'b0; d0.addr = '0; d0.wdata = '0;
        tick;
        tick;
        check("rst_ready", {31'd0, d2.ready}, 32'd0);
        check("rst_busy", {31'd0, d2.busy}, 32'd0);
        check("rst_err", {31'd0, d2.err}, 32'd0);
        check("rst_rdata", d2.rdata, 32'd0);
        check("rst0_busy", {31'd0, d0.busy}, 32'd0);
        check("rst0_rdata", d0.rdata, 32'd0);
        rst = 1'b0;
        tick;

        // Store then load with cycle-by-cycle timing
        d2.req = 1'b1; d2.we = 1'b1;
        d2.addr = 16'h0010; d2.wdata = 32'hDEADBEEF;
        tick;
        d2.req = 1'b0;
        check("t1_busy1", {31'd0, d2.busy}, 32'd1);
        check("t1_rdy1", {31'd0, d2.ready}, 32'd0);
        tick;
        check("t1_busy2", {31'd0, d2.busy}, 32'd1);
        check("t1_rdy2", {31'd0, d2.ready}, 32'd0);
        tick;
        check("t1_busy3", {31'd0, d2.busy}, 32'd1);
        check("t1_rdy3", {31'd0, d2.ready}, 32'd1);
        check("t1_err3", {31'd0, d2.err}, 32'd0);
        tick;
        check("t1_busy4", {31'd0, d2.busy}, 32'd0);
        check("t1_rdy4", {31'd0, d2.ready}, 32'd0);
        ld(1'b0, 16'h0010, 32'hDEADBEEF, "t1_ld");

        // req held high: store/load pairs every 4 cycles
        d2.req = 1'b1;
        rc = 0;
        for (int i = 0; i < 6; i++) begin
            w = (i % 2 == 0);
            d2.we = w;
            d2.addr = addrs[i/2];
            d2.wdata = vals[i/2];
            for (int k = 1; k <= 4; k++) begin
                tick;
                rc += int'(d2.ready);
                if (k == 3) begin
                    check("t2_rdy", {31'd0, d2.ready}, 32'd1);
                    if (!w) check("t2_rd", d2.rdata, vals[i/2]);
                end
            end
        end
        d2.req = 1'b0;
        tick;
        check("t2_cnt", 32'(rc), 32'd6);
        check("t2_idle", {31'd0, d2.busy}, 32'd0);

        // Request during busy is ignored
        st(1'b0, 16'h0020, 32'h11112222, "t3_pre");
        ld(1'b0, 16'h0001, vals[1], "t3_preld");
        rc = 0;
        d2.req = 1'b1; d2.we = 1'b1;
        d2.addr = 16'h0005; d2.wdata = 32'h00000055;
        tick;
        rc += int'(d2.ready);
        d2.req = 1'b1; d2.we = 1'b0; d2.addr = 16'h0020;
        tick;
        rc += int'(d2.ready);
        d2.req = 1'b0;
        for (int k = 3; k <= 8; k++) begin
            tick;
            rc += int'(d2.ready);
            if (k == 3) begin
                check("t3_rdy", {31'd0, d2.ready}, 32'd1);
                check("t3_rdata", d2.rdata, vals[1]);
            end
        end
        check("t3_cnt", 32'(rc), 32'd1);
        ld(1'b0, 16'h0020, 32'h11112222, "t3_ld20");
        ld(1'b0, 16'h0005, 32'h00000055, "t3_ld05");

        // Out-of-range store
        txn(1'b0, 1'b1, 16'h0100, 32'hCAFEF00D, rd, e, lat);
        check("t4_lat", 32'(lat), 32'd3);
        check("t4_err", {31'd0, e}, 32'd1);
        check("t4_rdata", rd, 32'd0);
        ld(1'b0, 16'h0000, vals[0], "t4_ld0");

        // Reset before RESP-entry drops the store
        st(1'b0, 16'h0033, 32'h00000000, "t5_pre");
        d2.req = 1'b1; d2.we = 1'b1;
        d2.addr = 16'h0033; d2.wdata = 32'h12345678;
        tick;
        d2.req = 1'b0;
        tick;
        rst = 1'b1;
        tick;
        check("t5_busy", {31'd0, d2.busy}, 32'd0);
        check("t5_rdy", {31'd0, d2.ready}, 32'd0);
        rst = 1'b0;
        ld(1'b0, 16'h0033, 32'h00000000, "t5_ld");
        ld(1'b0, 16'h0010, 32'hDEADBEEF, "t5_keep");

        // Reset and req in the same cycle
        rst = 1'b1;
        d2.req = 1'b1; d2.we = 1'b0; d2.addr = 16'h0010;
        tick;
        rst = 1'b0;
        d2.req = 1'b0;
        check("t7_busy", {31'd0, d2.busy}, 32'd0);
        tick;
        check("t7_rdy", {31'd0, d2.ready}, 32'd0);

        // WAIT=0 instance
        st(1'b1, 16'h0007, 32'hA5A5A5A5, "t6_st");
        ld(1'b1, 16'h0007, 32'hA5A5A5A5, "t6_ld");
        d0.req = 1'b1; d0.we = 1'b0; d0.addr = 16'h0007;
        rc = 0;
        for (int k = 1; k <= 6; k++) begin
            tick;
            rc += int'(d0.ready);
            check("t6_b2b", {31'd0, d0.ready}, 32'(k % 2));
            if (k % 2 == 1) check("t6_rd", d0.rdata, 32'hA5A5A5A5);
        end
        d0.req = 1'b0;
        check("t6_cnt", 32'(rc), 32'd3);
        tick;

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
